// File: rtl/gpr_bank.sv
// General-purpose register bank: two combinational read ports with same-cycle
// write bypass, two byte-enabled write ports (port 1 = load return, wins on
// overlap), a per-register pending scoreboard and a multi-cycle clear sweep.
module gpr_bank #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_addr_0,
    output logic [DATA_W-1:0]   rd_data_0,
    output logic                rd_busy_0,
    input  logic [ADDR_W-1:0]   rd_addr_1,
    output logic [DATA_W-1:0]   rd_data_1,
    output logic                rd_busy_1,
    input  logic                we_0,
    input  logic [ADDR_W-1:0]   wr_addr_0,
    input  logic [DATA_W-1:0]   wr_data_0,
    input  logic [DATA_W/8-1:0] wr_be_0,
    input  logic                we_1,
    input  logic [ADDR_W-1:0]   wr_addr_1,
    input  logic [DATA_W-1:0]   wr_data_1,
    input  logic [DATA_W/8-1:0] wr_be_1,
    input  logic                sb_set,
    input  logic [ADDR_W-1:0]   sb_addr,
    input  logic                clr_req,
    output logic                clr_busy
);

    localparam int unsigned BeW     = DATA_W / 8;
    localparam logic [0:0]  StIdle  = 1'b0;
    localparam logic [0:0]  StSweep = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [DATA_W-1:0]   gpr_q  [NUM_REGS];
    logic [DATA_W-1:0]   gpr_d  [NUM_REGS];
    logic [DATA_W-1:0]   merged [NUM_REGS];
    logic                idle;
    logic                wen_0, wen_1;

    // Writes and scoreboard updates only take effect outside a clear sweep.
    assign idle     = (state_q == StIdle);
    assign wen_0    = we_0 & idle;
    assign wen_1    = we_1 & idle;
    assign clr_busy = (state_q == StSweep);

    // Per-register view with this cycle's writes merged in (port 1 over port 0).
    // Feeds both the read bypass and the next stored value; addresses beyond
    // NUM_REGS match no register, so such writes vanish and such reads give 0.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            merged[i] = gpr_q[i];
            for (int unsigned b = 0; b < BeW; b++) begin
                if (wen_0 && wr_be_0[b] && (wr_addr_0 == ADDR_W'(i))) begin
                    merged[i][8*b +: 8] = wr_data_0[8*b +: 8];
                end
                if (wen_1 && wr_be_1[b] && (wr_addr_1 == ADDR_W'(i))) begin
                    merged[i][8*b +: 8] = wr_data_1[8*b +: 8];
                end
            end
            if ((ZERO_REG != 0) && (i == 0)) begin
                merged[i] = '0;
            end
        end
    end

    // Read ports: bypassed data, and busy drops as soon as the load returns.
    always_comb begin
        rd_data_0 = '0;
        rd_busy_0 = 1'b0;
        rd_data_1 = '0;
        rd_busy_1 = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_0 == ADDR_W'(i)) begin
                rd_data_0 = merged[i];
                rd_busy_0 = pend_q[i] & ~(wen_1 && (wr_addr_1 == rd_addr_0));
            end
            if (rd_addr_1 == ADDR_W'(i)) begin
                rd_data_1 = merged[i];
                rd_busy_1 = pend_q[i] & ~(wen_1 && (wr_addr_1 == rd_addr_1));
            end
        end
    end

    // Next state: register writes, scoreboard and the clear sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            gpr_d[i] = merged[i];
        end
        case (state_q)
            StIdle: begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (wen_1 && (wr_addr_1 == ADDR_W'(i))) begin
                        pend_d[i] = 1'b0;
                    end
                    // Applied after the clear so a coincident set wins.
                    if (sb_set && (sb_addr == ADDR_W'(i))) begin
                        pend_d[i] = 1'b1;
                    end
                end
                if (ZERO_REG != 0) begin
                    pend_d[0] = 1'b0;
                end
                if (clr_req) begin
                    state_d = StSweep;
                    idx_d   = '0;
                    pend_d  = '0;
                end
            end
            StSweep: begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (idx_q == ADDR_W'(i)) begin
                        gpr_d[i] = '0;
                    end
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset that also aborts a sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            pend_q  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

endmodule

// File: doc/gpr_bank.md
Name: gpr_bank

Overview:
- Parametrised next-generation general-purpose register bank for the CPU core.
- Two combinational read ports and two write ports with byte enables. Port 0 carries ALU writeback; port 1 carries load return.
- Same-cycle write-to-read bypass, optional hardwired zero register, and a per-register pending (scoreboard) bit for in-flight loads.
- A multi-cycle clear sequencer zeroes the bank on request without a full reset.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers; must be ≤ 2^ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never pending.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rd_addr_0  in  ADDR_W  read port 0 address
- rd_data_0  out  DATA_W  read port 0 data (combinational)
- rd_busy_0  out  1  pending bit of rd_addr_0 (combinational)
- rd_addr_1  in  ADDR_W  read port 1 address
- rd_data_1  out  DATA_W  read port 1 data (combinational)
- rd_busy_1  out  1  pending bit of rd_addr_1 (combinational)
- we_0  in  1  write enable port 0, active-high
- wr_addr_0  in  ADDR_W  write address port 0
- wr_data_0  in  DATA_W  write data port 0
- wr_be_0  in  DATA_W/8  byte enables port 0
- we_1  in  1  write enable port 1 (load return), active-high
- wr_addr_1  in  ADDR_W  write address port 1
- wr_data_1  in  DATA_W  write data port 1
- wr_be_1  in  DATA_W/8  byte enables port 1
- sb_set  in  1  mark sb_addr pending
- sb_addr  in  ADDR_W  register to mark pending
- clr_req  in  1  start clear sweep (single-cycle pulse)
- clr_busy  out  1  clear sweep in progress

Behaviour:
Reset
- All registers = 0, all pending bits = 0, FSM = IDLE, clr_busy = 0, sweep index = 0.
- Reset applies at the next clk edge and aborts any sweep in progress.
- rd_data_* and rd_busy_* are combinational and therefore also read 0 after reset.

Writes (FSM in IDLE)
- On the clk edge, each enabled port writes only the bytes whose be bit is 1.
- Same address and same byte on both ports: port 1 wins. Disjoint bytes merge.
- Addresses ≥ NUM_REGS: writes ignored. Reads of such addresses return 0, busy 0.

Reads and bypass
- rd_data_n = stored value with same-cycle enabled writes merged per byte (port 1 over port 0). Zero-cycle latency.
- With ZERO_REG = 1, address 0 always reads 0, whatever the writes.

Scoreboard
- sb_set sets pend[sb_addr] at the clk edge.
- A we_1 write (any be) clears pend[wr_addr_1]. Port 0 writes never clear.
- sb_set and a port-1 clear on the same address in the same cycle: set wins.
- rd_busy_n = pend[rd_addr_n] AND NOT (we_1 AND wr_addr_1 == rd_addr_n), so busy drops in the same cycle the bypassed load data appears.
- ZERO_REG = 1: pend[0] is never set.

Clear FSM (states IDLE, SWEEP)
- IDLE: clr_req = 1 → SWEEP at the next edge. On that same edge the index is set to 0, all pending bits are cleared, and a same-cycle sb_set is dropped. Writes in the clr_req cycle still commit.
- SWEEP: clr_busy = 1. Each cycle zeroes gpr[index] and increments the index. After the cycle that zeroes NUM_REGS-1, return to IDLE. clr_busy is high for exactly NUM_REGS cycles.
- During SWEEP:
  - we_0, we_1 and sb_set are ignored (no state change, no bypass).
  - clr_req is ignored.
  - Reads return the current array contents (partially cleared) with rd_busy = 0.
- rst during SWEEP: the full reset above; FSM returns to IDLE.

Test Plan:
- Reset, then read addr 3 and addr 0 on both ports → rd_data = 0, rd_busy = 0, clr_busy = 0.
- we_0 addr 5 data 0x11223344 be 0xF; next cycle we_1 addr 5 data 0xAABBCCDD be 0x3 → read addr 5 = 0x1122CCDD. During the second cycle, bypass on rd_addr_0 = 5 shows 0x1122CCDD before the edge.
- Same-cycle collision: we_0 addr 7 data 0x0000FFFF be 0xF and we_1 addr 7 data 0x12345678 be 0xC → bypass and stored value = 0x1234FFFF.
- ZERO_REG = 1: we_0 addr 0 data 0xDEADBEEF be 0xF, plus sb_set addr 0 → read addr 0 = 0, rd_busy = 0.
- sb_set addr 9 → rd_busy = 1 next cycle. we_1 addr 9 data 0x55 be 0xF → same-cycle rd_busy_0 = 0 and rd_data_0 = 0x55; pending stays 0 afterwards. sb_set and we_1 on addr 9 in the same cycle → busy = 1 next cycle.
- Fill r1..r31 with nonzero values and set pend[4]; pulse clr_req → clr_busy high for exactly 32 cycles. A we_0 to r2 mid-sweep is ignored. All registers = 0 and rd_busy_* = 0 at the end. Repeat with rst at sweep cycle 10 → immediate full clear, clr_busy = 0 on the next cycle.
